// File: rtl/pcie_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the PCIe TX LocalLink port between
// the completion generator (IN0) and the request generator (IN1), with a source-stall watchdog.
module pcie_tx_arbiter #(
    parameter int TIMEOUT   = 256,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 IN0_SOF_N,
    input  logic                 IN0_EOF_N,
    input  logic [63:0]          IN0_DATA,
    input  logic [7:0]           IN0_REM_N,
    input  logic                 IN0_SRC_RDY_N,
    output logic                 IN0_DST_RDY_N,
    input  logic [1:0]           IN0_TYPE,
    output logic                 IN0_DSC_N,
    input  logic                 IN1_SOF_N,
    input  logic                 IN1_EOF_N,
    input  logic [63:0]          IN1_DATA,
    input  logic [7:0]           IN1_REM_N,
    input  logic                 IN1_SRC_RDY_N,
    output logic                 IN1_DST_RDY_N,
    input  logic [1:0]           IN1_TYPE,
    output logic                 IN1_DSC_N,
    output logic                 TX_SOF_N,
    output logic                 TX_EOF_N,
    output logic [63:0]          TX_DATA,
    output logic [7:0]           TX_REM_N,
    output logic                 TX_SRC_RDY_N,
    output logic                 TX_SRC_DCS_N,
    input  logic                 TX_DST_RDY_N,
    input  logic                 TX_DST_DCS_N,
    input  logic [2:0]           TX_BUF_AV,
    output logic [CNT_WIDTH-1:0] PKT_CNT0,
    output logic [CNT_WIDTH-1:0] PKT_CNT1
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic        rr;
    logic        rr_next;
    logic [15:0] stall;
    logic [15:0] stall_next;
    logic        started;
    logic        started_next;
    logic        wd_fire;
    logic        wd_fire_next;
    logic        cnt_inc0;
    logic        cnt_inc1;

    logic        elig0;
    logic        elig1;
    logic        granted;
    logic        g_sof_n;
    logic        g_eof_n;
    logic [63:0] g_data;
    logic [7:0]  g_rem_n;
    logic        g_src_rdy_n;
    logic        core_dcs;
    logic        abort;
    logic        xfer;

    // TX_BUF_AV bit order is non-posted, posted, completion; class 11 rides as non-posted.
    function automatic logic buf_ok(input logic [1:0] tlp_type, input logic [2:0] buf_av);
        logic ok;
        case (tlp_type)
            2'b00:   ok = buf_av[1];
            2'b01:   ok = buf_av[0];
            2'b10:   ok = buf_av[2];
            default: ok = buf_av[0];
        endcase
        return ok;
    endfunction

    // Eligibility and the granted-source view shared by control and output logic.
    always_comb begin
        elig0   = !IN0_SRC_RDY_N && !IN0_SOF_N && buf_ok(IN0_TYPE, TX_BUF_AV);
        elig1   = !IN1_SRC_RDY_N && !IN1_SOF_N && buf_ok(IN1_TYPE, TX_BUF_AV);
        granted = (state == GNT0) || (state == GNT1);
        if (state == GNT1) begin
            g_sof_n     = IN1_SOF_N;
            g_eof_n     = IN1_EOF_N;
            g_data      = IN1_DATA;
            g_rem_n     = IN1_REM_N;
            g_src_rdy_n = IN1_SRC_RDY_N;
        end else begin
            g_sof_n     = IN0_SOF_N;
            g_eof_n     = IN0_EOF_N;
            g_data      = IN0_DATA;
            g_rem_n     = IN0_REM_N;
            g_src_rdy_n = IN0_SRC_RDY_N;
        end
        core_dcs = granted && !TX_DST_DCS_N;
        abort    = wd_fire || core_dcs;
        xfer     = granted && !wd_fire && !g_src_rdy_n && !TX_DST_RDY_N;
    end

    // Next-state, round-robin pointer, stall watchdog and counter enables.
    always_comb begin
        state_next   = state;
        rr_next      = rr;
        stall_next   = stall;
        started_next = started;
        wd_fire_next = 1'b0;
        cnt_inc0     = 1'b0;
        cnt_inc1     = 1'b0;
        case (state)
            IDLE: begin
                stall_next   = 16'd0;
                started_next = 1'b0;
                if (elig0 && (!elig1 || !rr)) begin
                    state_next = GNT0;
                    rr_next    = 1'b1;
                end else if (elig1) begin
                    state_next = GNT1;
                    rr_next    = 1'b0;
                end else begin
                    state_next = IDLE;
                end
            end
            GNT0, GNT1: begin
                // Discontinue of either origin beats a coincident EOF transfer.
                if (abort) begin
                    state_next = IDLE;
                end else if (xfer && !g_eof_n) begin
                    state_next = IDLE;
                    cnt_inc0   = (state == GNT0);
                    cnt_inc1   = (state == GNT1);
                end else begin
                    if (xfer) begin
                        started_next = 1'b1;
                    end else begin
                        started_next = started;
                    end
                    if (!g_src_rdy_n) begin
                        stall_next = 16'd0;
                    end else if (started) begin
                        stall_next   = stall + 16'd1;
                        wd_fire_next = (stall_next == STALL_LIMIT);
                    end else begin
                        stall_next = 16'd0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Zero-latency TX mux; RESET forces idle values combinationally so a mid-packet reset is immediate.
    always_comb begin
        TX_SOF_N      = 1'b1;
        TX_EOF_N      = 1'b1;
        TX_DATA       = 64'd0;
        TX_REM_N      = 8'd0;
        TX_SRC_RDY_N  = 1'b1;
        TX_SRC_DCS_N  = 1'b1;
        IN0_DST_RDY_N = 1'b1;
        IN1_DST_RDY_N = 1'b1;
        IN0_DSC_N     = 1'b1;
        IN1_DSC_N     = 1'b1;
        if (RESET) begin
            TX_SRC_RDY_N = 1'b1;
        end else begin
            case (state)
                GNT0: begin
                    TX_SOF_N      = g_sof_n;
                    TX_EOF_N      = g_eof_n;
                    TX_DATA       = g_data;
                    TX_REM_N      = g_rem_n;
                    TX_SRC_RDY_N  = g_src_rdy_n | wd_fire;
                    TX_SRC_DCS_N  = !wd_fire;
                    IN0_DST_RDY_N = TX_DST_RDY_N;
                    IN0_DSC_N     = !abort;
                end
                GNT1: begin
                    TX_SOF_N      = g_sof_n;
                    TX_EOF_N      = g_eof_n;
                    TX_DATA       = g_data;
                    TX_REM_N      = g_rem_n;
                    TX_SRC_RDY_N  = g_src_rdy_n | wd_fire;
                    TX_SRC_DCS_N  = !wd_fire;
                    IN1_DST_RDY_N = TX_DST_RDY_N;
                    IN1_DSC_N     = !abort;
                end
                default: TX_SRC_RDY_N = 1'b1;
            endcase
        end
    end

    // State, pointer, watchdog and packet counter registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            rr       <= 1'b0;
            stall    <= 16'd0;
            started  <= 1'b0;
            wd_fire  <= 1'b0;
            PKT_CNT0 <= {CNT_WIDTH{1'b0}};
            PKT_CNT1 <= {CNT_WIDTH{1'b0}};
        end else begin
            state   <= state_next;
            rr      <= rr_next;
            stall   <= stall_next;
            started <= started_next;
            wd_fire <= wd_fire_next;
            if (cnt_inc0) begin
                PKT_CNT0 <= PKT_CNT0 + CNT_WIDTH'(1);
            end
            if (cnt_inc1) begin
                PKT_CNT1 <= PKT_CNT1 + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Bench for pcie_tx_arbiter: grant-decision vector table plus scoreboarded packet sequences.
module tb_pcie_tx_arbiter;

    localparam int TIMEOUT   = 8;
    localparam int CNT_WIDTH = 16;

    typedef struct {
        logic        src;
        logic [1:0]  typ;
        logic        sof_n;
        logic        eof_n;
        logic [63:0] data;
        logic [7:0]  rem_n;
    } beat_t;

    typedef struct {
        bit         en0;
        logic [1:0] typ0;
        bit         en1;
        logic [1:0] typ1;
        logic [2:0] av;
        int         sel;
    } gvec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 in0_sof_n, in0_eof_n, in0_src_rdy_n, in0_dst_rdy_n, in0_dsc_n;
    logic                 in1_sof_n, in1_eof_n, in1_src_rdy_n, in1_dst_rdy_n, in1_dsc_n;
    logic [63:0]          in0_data, in1_data, tx_data;
    logic [7:0]           in0_rem_n, in1_rem_n, tx_rem_n;
    logic [1:0]           in0_type, in1_type;
    logic                 tx_sof_n, tx_eof_n, tx_src_rdy_n, tx_src_dcs_n;
    logic                 tx_dst_rdy_n, tx_dst_dcs_n;
    logic [2:0]           tx_buf_av;
    logic [CNT_WIDTH-1:0] pkt_cnt0, pkt_cnt1;

    beat_t src0_q[$];
    beat_t src1_q[$];
    beat_t exp_q[$];
    bit    hold0 = 1'b0;
    bit    hold1 = 1'b0;
    int    pkt_seq = 0;
    int    checks = 0;
    int    failures = 0;
    gvec_t tbl[12];

    pcie_tx_arbiter #(.TIMEOUT(TIMEOUT), .CNT_WIDTH(CNT_WIDTH)) dut (
        .CLK(clk), .RESET(rst),
        .IN0_SOF_N(in0_sof_n), .IN0_EOF_N(in0_eof_n), .IN0_DATA(in0_data), .IN0_REM_N(in0_rem_n),
        .IN0_SRC_RDY_N(in0_src_rdy_n), .IN0_DST_RDY_N(in0_dst_rdy_n), .IN0_TYPE(in0_type), .IN0_DSC_N(in0_dsc_n),
        .IN1_SOF_N(in1_sof_n), .IN1_EOF_N(in1_eof_n), .IN1_DATA(in1_data), .IN1_REM_N(in1_rem_n),
        .IN1_SRC_RDY_N(in1_src_rdy_n), .IN1_DST_RDY_N(in1_dst_rdy_n), .IN1_TYPE(in1_type), .IN1_DSC_N(in1_dsc_n),
        .TX_SOF_N(tx_sof_n), .TX_EOF_N(tx_eof_n), .TX_DATA(tx_data), .TX_REM_N(tx_rem_n),
        .TX_SRC_RDY_N(tx_src_rdy_n), .TX_SRC_DCS_N(tx_src_dcs_n),
        .TX_DST_RDY_N(tx_dst_rdy_n), .TX_DST_DCS_N(tx_dst_dcs_n), .TX_BUF_AV(tx_buf_av),
        .PKT_CNT0(pkt_cnt0), .PKT_CNT1(pkt_cnt1)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Queues one packet on a source; the first nexp beats are expected on TX in load order.
    task automatic load_pkt(input bit src, input logic [1:0] typ, input int nb, input int nexp);
        beat_t b;
        for (int k = 0; k < nb; k++) begin
            b.src   = src;
            b.typ   = typ;
            b.sof_n = (k == 0) ? 1'b0 : 1'b1;
            b.eof_n = (k == nb - 1) ? 1'b0 : 1'b1;
            b.data  = {4'(src), 12'(pkt_seq), 16'(k), 32'($urandom)};
            b.rem_n = 8'($urandom);
            if (src) src1_q.push_back(b);
            else     src0_q.push_back(b);
            if (k < nexp) exp_q.push_back(b);
        end
        pkt_seq++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src0_q.delete();
        src1_q.delete();
        exp_q.delete();
        hold0 = 1'b0;
        hold1 = 1'b0;
        tx_dst_rdy_n = 1'b0;
        tx_dst_dcs_n = 1'b1;
        tx_buf_av    = 3'b111;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_empty(input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            @(negedge clk); #1;
            n++;
        end
        check("wait_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Source 0 model: advances on accepted beats, drops the rest of a packet on discontinue.
    initial begin
        bit acc, dsc;
        beat_t b;
        in0_src_rdy_n = 1'b1; in0_sof_n = 1'b1; in0_eof_n = 1'b1;
        in0_data = 64'd0; in0_rem_n = 8'd0; in0_type = 2'b00;
        forever begin
            @(negedge clk);
            acc = !in0_src_rdy_n && !in0_dst_rdy_n;
            dsc = !in0_dsc_n;
            @(posedge clk);
            #2;
            if (dsc) begin
                b.eof_n = 1'b1;
                while (src0_q.size() > 0 && b.eof_n == 1'b1) b = src0_q.pop_front();
            end else if (acc && src0_q.size() > 0) begin
                void'(src0_q.pop_front());
            end
            if (src0_q.size() > 0) begin
                in0_sof_n = src0_q[0].sof_n; in0_eof_n = src0_q[0].eof_n;
                in0_data  = src0_q[0].data;  in0_rem_n = src0_q[0].rem_n; in0_type = src0_q[0].typ;
            end else begin
                in0_sof_n = 1'b1; in0_eof_n = 1'b1; in0_data = 64'd0; in0_rem_n = 8'd0;
            end
            in0_src_rdy_n = (src0_q.size() == 0) || hold0;
        end
    end

    // Source 1 model, identical behaviour.
    initial begin
        bit acc, dsc;
        beat_t b;
        in1_src_rdy_n = 1'b1; in1_sof_n = 1'b1; in1_eof_n = 1'b1;
        in1_data = 64'd0; in1_rem_n = 8'd0; in1_type = 2'b00;
        forever begin
            @(negedge clk);
            acc = !in1_src_rdy_n && !in1_dst_rdy_n;
            dsc = !in1_dsc_n;
            @(posedge clk);
            #2;
            if (dsc) begin
                b.eof_n = 1'b1;
                while (src1_q.size() > 0 && b.eof_n == 1'b1) b = src1_q.pop_front();
            end else if (acc && src1_q.size() > 0) begin
                void'(src1_q.pop_front());
            end
            if (src1_q.size() > 0) begin
                in1_sof_n = src1_q[0].sof_n; in1_eof_n = src1_q[0].eof_n;
                in1_data  = src1_q[0].data;  in1_rem_n = src1_q[0].rem_n; in1_type = src1_q[0].typ;
            end else begin
                in1_sof_n = 1'b1; in1_eof_n = 1'b1; in1_data = 64'd0; in1_rem_n = 8'd0;
            end
            in1_src_rdy_n = (src1_q.size() == 0) || hold1;
        end
    end

    // TX monitor: every completed transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        beat_t e;
        if (rst === 1'b0 && tx_src_rdy_n === 1'b0 && tx_dst_rdy_n === 1'b0 && tx_dst_dcs_n === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual data=%h required no transfer", tx_data);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", tx_data, e.data);
                check("beat_ctl",
                      64'({in1_dst_rdy_n, in0_dst_rdy_n, tx_sof_n, tx_eof_n, tx_rem_n}),
                      64'({(e.src ? 2'b01 : 2'b10), e.sof_n, e.eof_n, e.rem_n}));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] exp_data;
        rst = 1'b1;
        tx_dst_rdy_n = 1'b0;
        tx_dst_dcs_n = 1'b1;
        tx_buf_av    = 3'b111;

        tbl[0]  = '{1'b1, 2'b10, 1'b0, 2'b00, 3'b100, 0};
        tbl[1]  = '{1'b1, 2'b10, 1'b0, 2'b00, 3'b011, 2};
        tbl[2]  = '{1'b0, 2'b00, 1'b1, 2'b00, 3'b010, 1};
        tbl[3]  = '{1'b1, 2'b10, 1'b1, 2'b01, 3'b111, 0};
        tbl[4]  = '{1'b1, 2'b10, 1'b1, 2'b00, 3'b101, 0};
        tbl[5]  = '{1'b1, 2'b10, 1'b1, 2'b00, 3'b010, 1};
        tbl[6]  = '{1'b0, 2'b00, 1'b1, 2'b11, 3'b001, 1};
        tbl[7]  = '{1'b0, 2'b00, 1'b1, 2'b11, 3'b110, 2};
        tbl[8]  = '{1'b1, 2'b01, 1'b1, 2'b11, 3'b001, 0};
        tbl[9]  = '{1'b0, 2'b00, 1'b0, 2'b00, 3'b111, 2};
        tbl[10] = '{1'b1, 2'b01, 1'b0, 2'b00, 3'b001, 0};
        tbl[11] = '{1'b1, 2'b10, 1'b1, 2'b10, 3'b011, 2};

        // Reset state while RESET is held.
        repeat (2) @(negedge clk);
        #1;
        check("reset_ctl", 64'({tx_sof_n, tx_eof_n, tx_src_rdy_n, tx_src_dcs_n,
                                in0_dst_rdy_n, in1_dst_rdy_n, in0_dsc_n, in1_dsc_n}), 64'hFF);
        check("reset_data", 64'({tx_data, tx_rem_n} != 72'd0), 64'd0);
        check("reset_cnt", 64'({pkt_cnt0, pkt_cnt1}), 64'd0);

        // Grant decision from a fresh reset; core held not-ready so nothing transfers.
        for (int i = 0; i < 12; i++) begin
            do_reset();
            tx_dst_rdy_n = 1'b1;
            tx_buf_av    = tbl[i].av;
            if (tbl[i].en0) load_pkt(1'b0, tbl[i].typ0, 1, 0);
            if (tbl[i].en1) load_pkt(1'b1, tbl[i].typ1, 1, 0);
            @(posedge clk);
            @(negedge clk); #1;
            if (tbl[i].sel == 0)      exp_data = src0_q[0].data;
            else if (tbl[i].sel == 1) exp_data = src1_q[0].data;
            else                      exp_data = 64'd0;
            check($sformatf("grant_vec%0d_rdy", i), 64'(tx_src_rdy_n), 64'(tbl[i].sel == 2));
            check($sformatf("grant_vec%0d_data", i), tx_data, exp_data);
        end

        // Single 4-beat completion on IN0: SOF accepted one cycle after it is presented.
        do_reset();
        tx_buf_av = 3'b100;
        load_pkt(1'b0, 2'b10, 4, 4);
        @(negedge clk); #1;
        check("a_not_yet", 64'(tx_src_rdy_n), 64'd1);
        @(negedge clk); #1;
        check("a_sof_xfer", 64'({tx_src_rdy_n, tx_sof_n, in0_dst_rdy_n}), 64'd0);
        repeat (3) @(negedge clk);
        #1;
        check("a_back_to_back", 64'(exp_q.size()), 64'd0);
        @(negedge clk); #1;
        check("a_cnt0", 64'(pkt_cnt0), 64'd1);

        // Both inputs contending with 2-beat packets: order 0,1,0,1 with one idle cycle between.
        do_reset();
        load_pkt(1'b0, 2'b10, 2, 2);
        load_pkt(1'b1, 2'b01, 2, 2);
        load_pkt(1'b0, 2'b10, 2, 2);
        load_pkt(1'b1, 2'b01, 2, 2);
        repeat (11) @(negedge clk);
        #1;
        check("b_one_left", 64'(exp_q.size()), 64'd1);
        @(negedge clk); #1;
        check("b_all_done", 64'(exp_q.size()), 64'd0);
        @(negedge clk); #1;
        check("b_cnts", 64'({pkt_cnt0, pkt_cnt1}), 64'({16'd2, 16'd2}));

        // Posted IN1 blocked by BUF_AV until posted space appears.
        tx_buf_av = 3'b101;
        load_pkt(1'b0, 2'b10, 2, 2);
        load_pkt(1'b1, 2'b00, 2, 2);
        repeat (6) @(negedge clk);
        #1;
        check("c_in1_blocked", 64'({exp_q.size() == 2, tx_src_rdy_n}), 64'b11);
        tx_buf_av = 3'b111;
        wait_empty(20);
        @(negedge clk); #1;
        check("c_cnts", 64'({pkt_cnt0, pkt_cnt1}), 64'({16'd3, 16'd3}));

        // Core discontinue on beat 2 of a 5-beat IN1 packet.
        @(posedge clk); #1;
        load_pkt(1'b1, 2'b01, 5, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        tx_dst_dcs_n = 1'b0;
        @(negedge clk); #1;
        check("d_dsc_pulse", 64'({in1_dsc_n, in0_dsc_n}), 64'b01);
        @(posedge clk); #1;
        tx_dst_dcs_n = 1'b1;
        @(negedge clk); #1;
        check("d_idle", 64'({in1_dsc_n, tx_src_rdy_n}), 64'b11);
        check("d_cnt1", 64'(pkt_cnt1), 64'd3);
        check("d_drained", 64'(exp_q.size()), 64'd0);

        // Watchdog: IN0 stalls after its first beat; discontinue TIMEOUT cycles after that beat.
        @(posedge clk); #1;
        load_pkt(1'b0, 2'b10, 4, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        hold0 = 1'b1;
        for (int k = 2; k <= TIMEOUT; k++) begin
            @(negedge clk); #1;
            check($sformatf("e_quiet%0d", k), 64'({tx_src_dcs_n, in0_dsc_n}), 64'b11);
        end
        @(negedge clk); #1;
        check("e_fire", 64'({tx_src_dcs_n, in0_dsc_n, tx_src_rdy_n}), 64'b001);
        @(negedge clk); #1;
        check("e_after", 64'({tx_src_dcs_n, in0_dsc_n}), 64'b11);
        check("e_cnt0", 64'(pkt_cnt0), 64'd3);
        hold0 = 1'b0;

        // RESET mid-packet for one cycle, then both request: IN0 first again.
        @(posedge clk); #1;
        load_pkt(1'b0, 2'b10, 4, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        src0_q.delete();
        @(negedge clk); #1;
        check("f_rst_ctl", 64'({tx_sof_n, tx_eof_n, tx_src_rdy_n, tx_src_dcs_n,
                                in0_dst_rdy_n, in1_dst_rdy_n, in0_dsc_n, in1_dsc_n}), 64'hFF);
        check("f_rst_data", tx_data, 64'd0);
        check("f_rst_rem", 64'(tx_rem_n), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        load_pkt(1'b0, 2'b10, 1, 1);
        load_pkt(1'b1, 2'b01, 1, 1);
        @(negedge clk); #1;
        check("f_cnt_cleared", 64'({pkt_cnt0, pkt_cnt1}), 64'd0);
        wait_empty(20);
        @(negedge clk); #1;
        check("f_cnts", 64'({pkt_cnt0, pkt_cnt1}), 64'({16'd1, 16'd1}));

        repeat (3) @(negedge clk);
        check("end_scoreboard", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
